// File: rtl/alu_seq_mul.sv
// Iterative shift-add multiplier that borrows a shared combinational ALU
// for its accumulate step. Returns the low DATA_LEN bits of a*b.
module alu_seq_mul #(
    parameter int unsigned DATA_LEN = 32,
    parameter int unsigned FUNC_LEN = 4,
    parameter logic [FUNC_LEN-1:0] FUNC_ADD = '0,
    parameter int unsigned CNT_LEN  = $clog2(DATA_LEN + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [DATA_LEN-1:0] req_a,
    input  logic [DATA_LEN-1:0] req_b,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DATA_LEN-1:0] resp_result,
    output logic [DATA_LEN-1:0] alu_a,
    output logic [DATA_LEN-1:0] alu_b,
    output logic [FUNC_LEN-1:0] alu_func,
    input  logic [DATA_LEN-1:0] alu_result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_LEN-1:0] CNT_MAX = CNT_LEN'(DATA_LEN);

    state_t              state;
    logic [DATA_LEN-1:0] acc;
    logic [DATA_LEN-1:0] mcand;
    logic [DATA_LEN-1:0] mplier;
    logic [CNT_LEN-1:0]  cnt;
    logic                step;

    // A step happens only while BUSY with multiplier bits left and iterations remaining
    always_comb begin
        step = (state == BUSY) && (mplier != '0) && (cnt != CNT_MAX);
    end

    // ALU operands: accumulate the (possibly masked) multiplicand, idle at zero otherwise
    always_comb begin
        alu_a    = '0;
        alu_b    = '0;
        alu_func = FUNC_ADD;
        if (step) begin
            alu_a = acc;
            alu_b = mplier[0] ? mcand : '0;
        end
    end

    // The accumulator is the result register; it is only observed while resp_valid is set
    always_comb begin
        resp_result = acc;
    end

    // Control FSM and datapath registers with registered handshake outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            acc        <= '0;
            mcand      <= '0;
            mplier     <= '0;
            cnt        <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        mcand     <= req_a;
                        mplier    <= req_b;
                        acc       <= '0;
                        cnt       <= '0;
                        req_ready <= 1'b0;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (step) begin
                        acc    <= alu_result;
                        mcand  <= {mcand[DATA_LEN-2:0], 1'b0};
                        mplier <= {1'b0, mplier[DATA_LEN-1:1]};
                        cnt    <= cnt + CNT_LEN'(1);
                    end else begin
                        resp_valid <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_mul.sv
// Directed and randomized checks of alu_seq_mul against a product/latency reference model.
module tb_alu_seq_mul;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_result;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_func;
    logic [31:0] alu_result;

    int checks = 0;
    int errors = 0;

    logic [31:0] aq[$];
    logic [31:0] bq[$];
    bit          func_bad;

    alu_seq_mul dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_result (resp_result),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_func    (alu_func),
        .alu_result  (alu_result)
    );

    // Shared ALU stand-in: ADD for function 0, anything else gives a visibly wrong answer
    assign alu_result = (alu_func == 4'd0) ? alu_a + alu_b : alu_a ^ alu_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
        if (q.size() > i) return q[i];
        return 32'hxxxxxxxx;
    endfunction

    // One full transaction: accept, watch the BUSY window, stall the response, hand it off
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input int stall,
                         input bit hold, input logic [31:0] ha, input logic [31:0] hb);
        logic [63:0] prod;
        logic [31:0] exp;
        int          k;
        int          busy;
        prod = {32'h0, a} * {32'h0, b};
        exp  = prod[31:0];
        k = 0;
        for (int i = 0; i < 32; i++) if (b[i]) k = i + 1;
        aq.delete();
        bq.delete();
        func_bad = 1'b0;

        @(negedge clk);
        resp_ready = 1'b0;
        check("ready_in_idle", 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_a     = a;
        req_b     = b;
        @(posedge clk);
        @(negedge clk);
        req_valid = hold;
        req_a     = hold ? ha : $urandom();
        req_b     = hold ? hb : $urandom();

        busy = 0;
        while (!resp_valid && busy < 40) begin
            aq.push_back(alu_a);
            bq.push_back(alu_b);
            if (alu_func !== 4'd0 || req_ready !== 1'b0) func_bad = 1'b1;
            busy++;
            @(negedge clk);
        end
        check("busy_cycles", 64'(busy), 64'(k + 1));
        check("busy_ctrl", 64'(func_bad), 64'd0);
        check("result", 64'(resp_result), 64'(exp));

        for (int s = 0; s <= stall; s++) begin
            resp_ready = (s == stall);
            if (s > 0) begin
                check("stall_result", 64'(resp_result), 64'(exp));
                check("stall_valid", 64'(resp_valid), 64'd1);
                check("stall_ready", 64'(req_ready), 64'd0);
            end
            if (s < stall) @(negedge clk);
        end
        @(posedge clk);
        #1;
        check("valid_drop", 64'(resp_valid), 64'd0);
        check("ready_back", 64'(req_ready), 64'd1);
    endtask

    initial begin
        int nz;
        rst        = 1'b0;
        req_valid  = 1'b0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_result", 64'(resp_result), 64'd0);
        check("rst_alu_a", 64'(alu_a), 64'd0);
        check("rst_alu_b", 64'(alu_b), 64'd0);
        rst = 1'b1;

        // 3 x 5: alu_b walks 3, 0, 12 then the exit cycle
        do_op(32'd3, 32'd5, 0, 1'b0, 32'd0, 32'd0);
        check("b_seq0", 64'(qget(bq, 0)), 64'd3);
        check("b_seq1", 64'(qget(bq, 1)), 64'd0);
        check("b_seq2", 64'(qget(bq, 2)), 64'd12);
        check("b_seq3", 64'(qget(bq, 3)), 64'd0);

        // Zero multiplier: no ALU activity at all
        do_op(32'h1234, 32'd0, 0, 1'b0, 32'd0, 32'd0);
        nz = 0;
        foreach (aq[i]) if (aq[i] !== 32'd0 || qget(bq, i) !== 32'd0) nz++;
        check("zero_alu_idle", 64'(nz), 64'd0);

        // Full width operands wrap to 1 after 32 steps
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0, 32'd0, 32'd0);

        // Backpressure with a pending request held on the input
        do_op(32'd7, 32'd6, 4, 1'b1, 32'd11, 32'd13);
        do_op(32'd11, 32'd13, 1, 1'b0, 32'd0, 32'd0);

        // Asynchronous reset in the middle of a 17-bit multiplier run
        @(negedge clk);
        req_valid = 1'b1;
        req_a     = 32'h0001_0000;
        req_b     = 32'h0000_8000;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("async_req_ready", 64'(req_ready), 64'd1);
        check("async_resp_valid", 64'(resp_valid), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        nz = 0;
        repeat (40) begin
            @(negedge clk);
            if (resp_valid !== 1'b0) nz++;
        end
        check("no_orphan_resp", 64'(nz), 64'd0);
        do_op(32'd9, 32'd9, 0, 1'b0, 32'd0, 32'd0);

        // Randomized operands with varied multiplier lengths and random consumer stalls
        for (int n = 0; n < 500; n++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = $urandom();
            rb = $urandom() >> $urandom_range(0, 31);
            if ($urandom_range(0, 15) == 0) rb = 32'd0;
            do_op(ra, rb, $urandom_range(0, 2), 1'b0, 32'd0, 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_seq_mul.md
Name: alu_seq_mul

Overview:
- Iterative shift-add multiplier that acts as the initiator toward the combinational ALU.
- Drives alu_a, alu_b and alu_func and consumes alu_result in the same cycle.
- Returns the low DATA_LEN bits of an unsigned product, which is identical to RV MUL.
- Sits between the EXU issue logic (valid/ready request) and a shared ALU instance.

Parameters:
- DATA_LEN, 32, operand/result width; matches the ALU data width (ISA width).
- FUNC_LEN, 4, width of alu_func; matches the ALU function-code width.
- FUNC_ADD, 0, ALU function code for ADD, driven on alu_func.
- CNT_LEN, $clog2(DATA_LEN+1), iteration counter width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request valid.
- req_ready  out  1  request ready; high only in IDLE.
- req_a  in  DATA_LEN  multiplicand.
- req_b  in  DATA_LEN  multiplier.
- resp_valid  out  1  result valid; high only in DONE.
- resp_ready  in  1  consumer accepts the result.
- resp_result  out  DATA_LEN  product, low DATA_LEN bits.
- alu_a  out  DATA_LEN  ALU operand A.
- alu_b  out  DATA_LEN  ALU operand B.
- alu_func  out  FUNC_LEN  ALU function select.
- alu_result  in  DATA_LEN  ALU result; combinational, same cycle.

Behaviour:
- Registers: state {IDLE, BUSY, DONE}, acc, mcand, mplier, cnt.
- Reset (rst=0, asynchronous, any state, including mid-operation):
  - state=IDLE; acc, mcand, mplier, cnt = 0.
  - req_ready=1, resp_valid=0, resp_result=0.
  - An in-flight operation is discarded; no response is produced for it.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready: mcand<=req_a, mplier<=req_b, acc<=0, cnt<=0, state<=BUSY.
- BUSY, each cycle:
  - If mplier==0 or cnt==DATA_LEN: state<=DONE; acc is unchanged; no step is performed.
  - Otherwise, step:
    - drive alu_a=acc, alu_b = mplier[0] ? mcand : 0, alu_func=FUNC_ADD;
    - acc<=alu_result;
    - mcand<=mcand<<1, dropping the MSB;
    - mplier<=mplier>>1;
    - cnt<=cnt+1.
  - req_ready=0 and resp_valid=0 throughout.
- DONE:
  - resp_valid=1; resp_result=acc, held stable.
  - On resp_ready: state<=IDLE.
  - Without resp_ready: stay in DONE indefinitely and keep req_ready=0.
  - There is no DONE->BUSY bypass; a new request is accepted only after a full cycle in IDLE.
- ALU outputs outside a BUSY step: alu_a=0, alu_b=0, alu_func=FUNC_ADD.
- Arithmetic:
  - All sums wrap modulo 2^DATA_LEN; the module never inspects ALU carry or overflow.
  - resp_result == (req_a*req_b) mod 2^DATA_LEN.
- Latency, with the request accepted at edge T:
  - k = position of the highest set bit of req_b plus 1 (k=0 if req_b==0).
  - BUSY occupies k+1 cycles, except k=DATA_LEN, which also occupies DATA_LEN+1 cycles (exit on cnt==DATA_LEN).
  - resp_valid rises at cycle T+k+2.
- req_a/req_b are sampled only at acceptance; later changes are ignored.
- req_valid is ignored in BUSY and DONE.
- resp_result is meaningful only while resp_valid=1. It is acc, so it stays 0 until the first step after reset.

Test Plan:
- 3×5 scenario:
  - Stimulus: req_a=3, req_b=5, accept at T, resp_ready=1.
  - Required: BUSY for T+1..T+4; alu_b sequence 3,0,12; resp_valid=1 at T+5 with resp_result=15; req_ready=1 again at T+6.
- Zero multiplier:
  - Stimulus: req_a=0x1234, req_b=0.
  - Required: no ALU step (alu_a=alu_b=0 throughout); resp_valid at T+2; resp_result=0.
- Full-width wrap:
  - Stimulus: req_a=req_b=0xFFFFFFFF.
  - Required: 32 steps, each with alu_func=FUNC_ADD; resp_valid at T+34; resp_result=0x00000001.
- Response backpressure:
  - Stimulus: 7×6, resp_ready held 0 for 4 cycles after resp_valid; req_valid held 1 with new operands.
  - Required: resp_result=42, stable for all 5 cycles; req_ready=0 until the cycle after the resp_ready handshake; the new request is then accepted.
- Async reset mid-operation:
  - Stimulus: 0x10000×0x8000; pull rst low at T+5, between clock edges.
  - Required: req_ready=1 and resp_valid=0 immediately, without waiting for a clock; no response is produced.
  - Then after release: 9×9 gives resp_result=81.
- Randomized back-to-back:
  - Stimulus: 500 random operand pairs, resp_ready random.
  - Required: every resp_result equals (a*b) mod 2^32; latency matches the k rule.
